ps2_kbd: RTL

- Receive-only PS/2 keyboard interface on the 6502 system bus at F400-F4FF, next to the ACIA and LED blocks.
- Synchronises the PS/2 clock and data lines, deframes 11-bit scan-code frames and checks odd parity.
- Buffers good bytes in a small FIFO and presents status, data and control registers to the CPU read mux.
- Raises a level IRQ that the top level ORs into CPU_IRQ.

---
 rtl/ps2_kbd_pkg.sv | 27 ++
 rtl/ps2_rx_frame.sv | 130 +++++++++++++
 rtl/ps2_kbd.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard block: CPU register map, STATUS/CTRL
// bit positions and the framer state encoding.
package ps2_kbd_pkg;

  // CPU register addresses (CPU_AB[1:0])
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS bit positions
  localparam int unsigned STAT_AVAIL = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_OVR   = 2;
  localparam int unsigned STAT_PERR  = 3;
  localparam int unsigned STAT_IRQ   = 7;

  // CTRL bit positions
  localparam int unsigned CTRL_IE = 0;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } frame_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive deframer: synchronises the PS/2 clock and data pins, detects
// falling clock edges, collects start/8 data/parity/stop bits and checks odd
// parity. A partial frame is abandoned after TIMEOUT_CYC cycles without an edge.
//
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   ps2_clk, ps2_dat asynchronous PS/2 pins
//   byte_valid       1-cycle pulse, the cycle after a good stop-bit edge
//   rx_byte          received byte, stable while byte_valid is high
//   perr_pulse       1-cycle pulse on a bad parity or stop bit
module ps2_rx_frame
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16000,
  parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       perr_pulse
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  frame_state_e           state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [CntW-1:0]        idle_cnt_q, idle_cnt_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   perr_q, perr_d;

  logic clk_s, dat_s, fall;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d   = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
    clk_prev_d   = clk_s;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    byte_valid_d = 1'b0;
    perr_d       = 1'b0;

    // Saturating count of cycles since the last falling edge
    if (fall) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != CntMax) begin
      idle_cnt_d = idle_cnt_q + CntW'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end

    unique case (state_q)
      StIdle: begin
        if (fall && !dat_s) begin
          state_d   = StData;
          bit_cnt_d = 3'd0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {dat_s, shift_q[7:1]};  // LSB arrives first
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = dat_s;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          if (dat_s && (^{shift_q, par_q})) byte_valid_d = 1'b1;
          else                              perr_d       = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Stalled partial frame is dropped silently
    if (state_q != StIdle && !fall && idle_cnt_q == CntMax) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q   <= '1;
      dat_sync_q   <= '1;
      clk_prev_q   <= 1'b1;
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      idle_cnt_q   <= '0;
      byte_valid_q <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      idle_cnt_q   <= idle_cnt_d;
      byte_valid_q <= byte_valid_d;
      perr_q       <= perr_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign rx_byte    = shift_q;
  assign perr_pulse = perr_q;

endmodule

// File: rtl/ps2_kbd.sv
// Receive-only PS/2 keyboard peripheral for the 6502 bus (F400-F4FF).
// Good scan-code bytes are queued in a FIFO and exposed through STATUS, DATA
// and CTRL registers; a level IRQ is raised while enabled and something needs
// attention.
//
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   cs, we, addr     CPU chip select, write enable, register select
//   din              CPU write data
//   dout             registered read data (1-cycle latency)
//   irq              level interrupt request, active high
//   ps2_clk, ps2_dat asynchronous PS/2 pins
module ps2_kbd
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 3,
  parameter int unsigned TIMEOUT_CYC = 16000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  input  logic       ps2_clk,
  input  logic       ps2_dat
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CountFull = (DEPTH_LOG2 + 1)'(Depth);

  logic       byte_valid, perr_pulse;
  logic [7:0] rx_byte;

  ps2_rx_frame #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .perr_pulse(perr_pulse)
  );

  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  rd_prev_q, rd_prev_d;
  logic                  ovr_q, ovr_d;
  logic                  perr_q, perr_d;
  logic                  ie_q, ie_d;
  logic                  irq_q, irq_d;
  logic [7:0]            dout_q, dout_d;

  logic avail, full, rd_data, pop, wr_en, ovf, reg_wr;
  logic [7:0] status;

  assign avail   = (count_q != '0);
  assign full    = (count_q == CountFull);
  assign rd_data = cs & ~we & (addr == REG_DATA);
  // Only the first cycle of a (possibly RDY-stretched) read pops
  assign pop     = rd_data & ~rd_prev_q & avail;
  // A push into a full FIFO still fits when the same cycle pops
  assign wr_en   = byte_valid & (~full | pop);
  assign ovf     = byte_valid & full & ~pop;
  assign reg_wr  = cs & we;

  always_comb begin
    status              = 8'h00;
    status[STAT_AVAIL]  = avail;
    status[STAT_FULL]   = full;
    status[STAT_OVR]    = ovr_q;
    status[STAT_PERR]   = perr_q;
    status[STAT_IRQ]    = irq_q;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_prev_d = rd_data;
    ovr_d     = ovr_q;
    perr_d    = perr_q;
    ie_d      = ie_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    if (wr_en && !pop)      count_d = count_q + (DEPTH_LOG2 + 1)'(1);
    else if (!wr_en && pop) count_d = count_q - (DEPTH_LOG2 + 1)'(1);

    // Hardware set wins over a same-cycle write-1-to-clear
    if (reg_wr && addr == REG_STATUS) begin
      if (din[STAT_OVR])  ovr_d  = 1'b0;
      if (din[STAT_PERR]) perr_d = 1'b0;
    end
    if (ovf)        ovr_d  = 1'b1;
    if (perr_pulse) perr_d = 1'b1;

    if (reg_wr && addr == REG_CTRL) ie_d = din[CTRL_IE];

    irq_d = ie_q & (avail | ovr_q | perr_q);

    // Uses pre-pop state so a DATA read returns the byte being popped
    unique case (addr)
      REG_STATUS: dout_d = status;
      REG_DATA:   dout_d = avail ? mem_q[rd_ptr_q] : 8'h00;
      REG_CTRL:   dout_d = {7'b0, ie_q};
      default:    dout_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_prev_q <= 1'b0;
      ovr_q     <= 1'b0;
      perr_q    <= 1'b0;
      ie_q      <= 1'b0;
      irq_q     <= 1'b0;
      dout_q    <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_prev_q <= rd_prev_d;
      ovr_q     <= ovr_d;
      perr_q    <= perr_d;
      ie_q      <= ie_d;
      irq_q     <= irq_d;
      dout_q    <= dout_d;
    end
  end

  logic unused_din;
  assign unused_din = ^{din[7:4], din[1]};

  assign dout = dout_q;
  assign irq  = irq_q;

endmodule
